// File: rtl/core_pkg.sv
// core_pkg: shared EX-stage entry types, ALU op codes and helpers.
package core_pkg;
   localparam int CORE_DATA_W = 32;
   localparam int CORE_OP_W   = 5;
   localparam int CORE_RD_W   = 5;
   localparam int CORE_PC_W   = 32;

   localparam logic [CORE_OP_W-1:0] ALU_OP_ADD = 5'd0;
   localparam logic [CORE_OP_W-1:0] ALU_OP_SUB = 5'd1;
   localparam logic [CORE_OP_W-1:0] ALU_OP_XOR = 5'd2;
   localparam logic [CORE_OP_W-1:0] ALU_OP_AND = 5'd3;
   localparam logic [CORE_OP_W-1:0] ALU_OP_OR  = 5'd4;

   typedef struct packed {
      logic [CORE_OP_W-1:0]   op;
      logic [CORE_DATA_W-1:0] in1;
      logic [CORE_DATA_W-1:0] in2;
      logic [CORE_RD_W-1:0]   rd;
      logic [CORE_PC_W-1:0]   pc;
   } ex_entry_t;

   typedef struct packed {
      logic [CORE_RD_W-1:0]   rd;
      logic [CORE_DATA_W-1:0] data;
      logic [CORE_PC_W-1:0]   pc;
   } wb_entry_t;

   // Saturating increment: a long-stalled counter must never wrap back to small values.
   function automatic logic [31:0] sat_inc32(input logic [31:0] v);
      return (&v) ? v : v + 32'd1;
   endfunction
endpackage

// File: rtl/core_pipe_skid.sv
// core_pipe_skid: main+skid two-entry buffer with flush; ready depends only on the skid flop.
module core_pipe_skid #(
   parameter type T = logic [31:0]
) (
   input  logic clk,
   input  logic rest,
   input  logic flush,
   input  logic i_valid,
   output logic o_ready,
   input  T     i_data,
   input  logic i_pop,
   output logic o_valid,
   output T     o_data
);
   logic r_main_v, r_skid_v;
   T     r_main, r_skid;
   logic w_fire, w_adv;

   assign o_ready = ~r_skid_v;
   assign w_fire  = i_valid & ~r_skid_v;
   assign w_adv   = ~r_main_v | i_pop;
   assign o_valid = r_main_v;
   assign o_data  = r_main;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
         r_main   <= '0;
         r_skid   <= '0;
      end else if (flush) begin
         r_main_v <= 1'b0;
         r_skid_v <= 1'b0;
      end else if (w_adv) begin
         r_main_v <= r_skid_v | w_fire;
         r_skid_v <= 1'b0;
         if (r_skid_v)
            r_main <= r_skid;
         else if (w_fire)
            r_main <= i_data;
      end else if (w_fire) begin
         r_skid   <= i_data;
         r_skid_v <= 1'b1;
      end
   end
endmodule

// File: rtl/core_id_ex_reg.sv
// core_id_ex_reg: ID->EX issue register with skid slot, ALU wait handshake and
// registered MEM/WB result slot.
module core_id_ex_reg
   import core_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int OP_W   = 5,
   parameter int RD_W   = 5
) (
   input  logic              clk,
   input  logic              rest,
   input  logic              flush,
   input  logic              id_valid,
   output logic              id_ready,
   input  logic [OP_W-1:0]   id_op,
   input  logic [DATA_W-1:0] id_in1,
   input  logic [DATA_W-1:0] id_in2,
   input  logic [RD_W-1:0]   id_rd,
   input  logic [31:0]       id_pc,
   output logic [OP_W-1:0]   alu_op,
   output logic [DATA_W-1:0] alu_in1,
   output logic [DATA_W-1:0] alu_in2,
   output logic              alu_op_wait_handle,
   input  logic              alu_op_ready,
   input  logic [DATA_W-1:0] alu_out,
   output logic              wb_valid,
   input  logic              wb_ready,
   output logic [RD_W-1:0]   wb_rd,
   output logic [DATA_W-1:0] wb_data,
   output logic [31:0]       wb_pc,
   output logic [31:0]       stall_cnt
);
   typedef struct packed {
      logic [OP_W-1:0]   op;
      logic [DATA_W-1:0] in1;
      logic [DATA_W-1:0] in2;
      logic [RD_W-1:0]   rd;
      logic [31:0]       pc;
   } ex_t;

   ex_t               w_id_entry, w_main;
   logic              w_main_v, w_out_free, w_retire;
   logic              r_out_v;
   logic [RD_W-1:0]   r_out_rd;
   logic [DATA_W-1:0] r_out_data;
   logic [31:0]       r_out_pc, r_stall_cnt;

   assign w_id_entry = {id_op, id_in1, id_in2, id_rd, id_pc};

   core_pipe_skid #(.T(ex_t)) u_pipe (
      .clk     (clk),
      .rest    (rest),
      .flush   (flush),
      .i_valid (id_valid),
      .o_ready (id_ready),
      .i_data  (w_id_entry),
      .i_pop   (w_retire),
      .o_valid (w_main_v),
      .o_data  (w_main)
   );

   // A retire in the flush cycle is dropped so the redirected op never reaches WB.
   assign w_out_free = ~r_out_v | wb_ready;
   assign w_retire   = w_main_v & alu_op_ready & w_out_free & ~flush;

   assign alu_op             = w_main_v ? w_main.op  : '0;
   assign alu_in1            = w_main_v ? w_main.in1 : '0;
   assign alu_in2            = w_main_v ? w_main.in2 : '0;
   assign alu_op_wait_handle = w_main_v & ~w_out_free;

   assign wb_valid  = r_out_v;
   assign wb_rd     = r_out_rd;
   assign wb_data   = r_out_data;
   assign wb_pc     = r_out_pc;
   assign stall_cnt = r_stall_cnt;

   always_ff @(posedge clk or negedge rest) begin
      if (!rest) begin
         r_out_v     <= 1'b0;
         r_out_rd    <= '0;
         r_out_data  <= '0;
         r_out_pc    <= '0;
         r_stall_cnt <= '0;
      end else begin
         if (w_retire) begin
            r_out_v    <= 1'b1;
            r_out_rd   <= w_main.rd;
            r_out_data <= alu_out;
            r_out_pc   <= w_main.pc;
         end else if (wb_ready) begin
            r_out_v <= 1'b0;
         end
         if (w_main_v & ~w_retire & ~flush)
            r_stall_cnt <= sat_inc32(r_stall_cnt);
      end
   end
endmodule

// File: doc/core_id_ex_reg.md
Name: core_id_ex_reg

Overview:
Issue/retire register between the ID stage and the EX ALU. It accepts decoded ops from ID with a valid/ready handshake and holds the active op in front of the ALU. It absorbs multi-cycle ALU ops via the ALU ready/wait pair, then registers the ALU result towards the MEM/WB stage. A skid slot keeps id_ready purely registered, and the block sustains one op per cycle.

Parameters:
DATA_W, 32, operand/result width
OP_W, 5, ALU op code width (matches ALU op field)
RD_W, 5, destination register index width

Ports:
clk  in  1  core clock
rest  in  1  asynchronous active-low reset
flush  in  1  kill all ops not yet retired (branch/trap redirect)
id_valid  in  1  ID presents an op
id_ready  out  1  block can accept an op; registered
id_op  in  OP_W  ALU op code
id_in1  in  DATA_W  operand 1
id_in2  in  DATA_W  operand 2
id_rd  in  RD_W  destination register
id_pc  in  32  PC of op
alu_op  out  OP_W  op to ALU
alu_in1  out  DATA_W  operand 1 to ALU
alu_in2  out  DATA_W  operand 2 to ALU
alu_op_wait_handle  out  1  ALU must hold its result (downstream stalled)
alu_op_ready  in  1  ALU result valid this cycle
alu_out  in  DATA_W  ALU result
wb_valid  out  1  registered result valid
wb_ready  in  1  downstream accepts result
wb_rd  out  RD_W  result destination
wb_data  out  DATA_W  result
wb_pc  out  32  result PC
stall_cnt  out  32  cycles an op sat in main without retiring

Behaviour:
- Storage: main entry (op, in1, in2, rd, pc, main_v), skid entry (same fields, skid_v), out entry (rd, data, pc, out_v).
- Reset (rest=0, async): all valids 0, all data 0, stall_cnt 0, id_ready=1, wb_valid=0, alu_* outputs 0.
- id_ready = ~skid_v (flop-derived, no combinational path from wb_ready or alu_op_ready).
- fire_in = id_valid & id_ready.
- out_free = ~out_v | wb_ready.
- retire = main_v & alu_op_ready & out_free.
- ALU drive: when main_v, alu_op/in1/in2 = main fields; otherwise all 0.
- alu_op_wait_handle = main_v & ~out_free.
- Out register:
  - On retire, load {main.rd, alu_out, main.pc} and set out_v=1.
  - Otherwise, if wb_ready, clear out_v.
  - wb_* reflect the out entry directly.
- Main register: when ~main_v or retire:
  - If skid_v, load from skid and clear skid_v.
  - Else if fire_in, load from id_*.
  - main_v becomes skid_v | fire_in.
- Skid register: fire_in while main_v & ~retire loads skid from id_* and sets skid_v=1. fire_in and a skid move cannot coincide, because id_ready=0 whenever skid_v=1.
- Flush:
  - Clears main_v and skid_v in the same edge; any fire_in that cycle is dropped.
  - A retire in the flush cycle is also suppressed, so out is not loaded.
  - An op already in out is retained (it is older than the redirect).
  - id_ready=1 on the next cycle.
- Latency: accept at edge N puts the op in main after N; with alu_op_ready=1 and out_free, wb_valid=1 after N+1. Throughput is 1 op/cycle when downstream is always ready.
- Multi-cycle ALU: main holds unchanged while alu_op_ready=0. ID may fill skid, then sees id_ready=0.
- stall_cnt: increments when main_v & ~retire & ~flush; saturates at 0xFFFFFFFF (no wrap); never cleared except by reset.
- No op reordering; ops retire strictly in ID acceptance order.

Decomposition:
- Shared package core_pkg (alongside core_define.sv ALU_OP_* constants): typedef struct packed ex_entry_t {op, in1, in2, rd, pc}, typedef wb_entry_t {rd, data, pc}.
- One natural sub-module: core_pipe_skid (generic main+skid 2-entry buffer with flush, parameterised on entry type). core_id_ex_reg instantiates it and adds the out register, handshake glue and stall_cnt.

Test Plan:
- Reset release with id_valid=0: id_ready=1, wb_valid=0, stall_cnt=0, alu_op=0 -> holds for 10 cycles.
- Back-to-back ADD ops (in1=5, in2=3, rd=1, then in1=7, in2=2, rd=2), alu_op_ready=1, wb_ready=1 -> wb_valid=1 two cycles after first accept; wb_data=8 then 9 on consecutive cycles.
- wb_ready=0 for 3 cycles with 3 ops streaming -> out holds op1, main op2, skid op3; id_ready=0 and alu_op_wait_handle=1; after wb_ready=1, results drain in order with no loss or duplication.
- Multi-cycle op: alu_op_ready=0 for 4 cycles on main op -> alu_in1/in2 stable; stall_cnt=4; retire on the cycle alu_op_ready=1.
- Flush with main and skid full, out holding an older op, and id_valid=1 in the flush cycle -> main_v=skid_v=0; incoming op dropped; older out op still delivered; id_ready=1 next cycle.
- Async reset asserted mid-stream (between clock edges) with all entries valid -> wb_valid and id-side state clear immediately; after release, the first new op completes with 2-cycle latency.
